mem_port_arbiter: RTL and testbench

Arbitrates one single-ported unified memory between the instruction-fetch stage (IF) and the load/store stage (MEM) of the 5-stage MIPS pipeline. It grants the bus to one requester at a time and sequences the bus handshake. It returns read data with a one-cycle done pulse and raises per-requester stall signals that feed the PCWrite/IF_ID_Write and pipeline-stall nets. MEM has priority over IF because it is the older instruction.

---
 rtl/mips_arb_pkg.sv | 23 ++
 rtl/arb_starve_ctr.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_arb_pkg.sv
// -----------------------------------------------------------------------------
// mips_arb_pkg
//   Shared types and constants for the IF/MEM unified-memory port arbiter.
//   - arb_state_e : bus-sequencing FSM states (IDLE / BUSY / RESP)
//   - OWN_IF / OWN_MEM : encoding of the registered grant owner bit
//   - ARB_ADDR_W / ARB_DATA_W : default address and data widths
// -----------------------------------------------------------------------------
package mips_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  // Owner of the current grant. MEM is the older instruction and wins ties.
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // sampling requests
    BUSY = 2'd1,  // bus_req held, waiting for bus_ack
    RESP = 2'd2   // done pulse to the owner, requests ignored
  } arb_state_e;

endpackage : mips_arb_pkg

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
//   Saturating count of MEM grants made while IF was waiting. When the count
//   reaches STARVE_MAX the arbiter hands the next contested grant to IF.
//   Only compiled when ARB_STARVE_GUARD_EN is defined.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     mem_grant_inc  a MEM grant is being made while IF is pending
//     if_grant       an IF grant is being made (clears the count)
//     at_max         count equals STARVE_MAX
// -----------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_grant_inc,
  input  logic if_grant,
  output logic at_max
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_grant) begin
      cnt_d = '0;
    end else if (mem_grant_inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);

endmodule : arb_starve_ctr
`endif

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the MIPS IF stage and the
//   MEM stage. MEM has priority (older instruction). One access is in flight
//   at a time: IDLE (grant + latch) -> BUSY (bus_req until bus_ack) -> RESP
//   (one-cycle done pulse to the owner) -> IDLE. Minimum access is 3 cycles.
//
//   Optional feature: define ARB_STARVE_GUARD_EN to let IF through after
//   STARVE_MAX consecutive MEM grants made while IF was waiting. Without it
//   priority is strictly MEM-first.
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     if_req/if_addr/if_kill     fetch request, address, redirect discard
//     if_rdata/if_done/if_stall  fetched word, completion pulse, stall
//     mem_req/mem_we/mem_addr/mem_wdata  load/store request
//     mem_rdata/mem_done/mem_stall       load data (0 for stores), pulse, stall
//     bus_req/bus_we/bus_addr/bus_wdata  memory request, held until bus_ack
//     bus_rdata/bus_ack          memory read data and one-cycle acknowledge
//   All outputs are registered except if_stall and mem_stall.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  // load / store
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  // memory bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  // A zero limit would make the counter width collapse to nothing.
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic if_ok;         // IF is requesting and not being redirected this cycle
  logic starve_force;  // starvation guard wants the next contested grant for IF
  logic grant_if;
  logic grant_mem;
  logic ack_hit;       // bus_ack only counts while a transaction is in BUSY

  // ---------------------------------------------------------------------------
  // Grant decision (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  assign if_ok     = if_req & ~if_kill;
  assign grant_if  = (state_q == IDLE) & if_ok & (~mem_req | starve_force);
  assign grant_mem = (state_q == IDLE) & mem_req & ~grant_if;
  assign ack_hit   = (state_q == BUSY) & bus_ack;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_grant_inc(grant_mem & if_ok),
    .if_grant     (grant_if),
    .at_max       (starve_force)
  );
`else
  assign starve_force = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register (also holds every registered output and datapath flop)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  // The data/address registers are reset too, because they drive outputs that
  // must read 0 out of reset; rst_n being asynchronous is what drops bus_req
  // immediately when reset hits mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_if || grant_mem) state_d = BUSY;
      BUSY:    if (bus_ack)               state_d = RESP;
      RESP:                               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d     = owner_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;   // done flags are single-cycle pulses
    mem_done_d  = 1'b0;

    // Latch the winning request; IF never writes.
    if (grant_mem) begin
      owner_d     = OWN_MEM;
      bus_req_d   = 1'b1;
      bus_we_d    = mem_we;
      bus_addr_d  = mem_addr;
      bus_wdata_d = mem_wdata;
    end else if (grant_if) begin
      owner_d     = OWN_IF;
      bus_req_d   = 1'b1;
      bus_we_d    = 1'b0;
      bus_addr_d  = if_addr;
      bus_wdata_d = '0;
    end

    // A redirect during an IF access lets the bus finish but swallows the
    // result; a kill in the ack cycle itself must also suppress the pulse.
    if ((state_q != IDLE) && (owner_q == OWN_IF) && if_kill) begin
      drop_d = 1'b1;
    end
    if (state_q == RESP) begin
      drop_d = 1'b0;
    end

    // Completion: bus_req falls the cycle after the ack, done rises with it.
    if (ack_hit) begin
      bus_req_d = 1'b0;
      bus_we_d  = 1'b0;
      if (owner_q == OWN_MEM) begin
        mem_done_d  = 1'b1;
        mem_rdata_d = bus_we_q ? '0 : bus_rdata;
      end else begin
        if_done_d   = ~(drop_q | if_kill);
        if_rdata_d  = bus_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

  // Stalls are combinational so the pipeline releases in the done cycle.
  assign if_stall  = if_req & ~if_done_q;
  assign mem_stall = mem_req & ~mem_done_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Requester agents replay queued
//   fetches / loads / stores, a bus responder acks after a programmable delay
//   and returns data from a fixed address->data function, and a monitor pops
//   scoreboard queues (bus transactions in grant order, done data per
//   requester) whenever the DUT produces them.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_tx_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_kill = 1'b0;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          mem_stall;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // agent work queues and scoreboard queues
  logic [AW-1:0] if_q[$];
  bus_tx_t       mem_q[$];
  logic [DW-1:0] if_exp[$];
  logic [DW-1:0] mem_exp[$];
  bus_tx_t       bus_exp[$];

  int   ack_delay = 1;
  int   ack_wait = 0;
  logic stray_ack = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // memory contents seen by the bus
  function automatic logic [DW-1:0] rdata_for(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
  endfunction

  task automatic push_fetch(input logic [AW-1:0] a, input bit expect_done);
    if_q.push_back(a);
    if (expect_done) if_exp.push_back(rdata_for(a));
  endtask

  task automatic push_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    mem_q.push_back('{we, a, wd});
    mem_exp.push_back(we ? 32'h0 : rdata_for(a));
  endtask

  task automatic exp_bus(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus_exp.push_back('{we, a, wd});
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while ((if_q.size() != 0 || mem_q.size() != 0 || if_req || mem_req || bus_req ||
            if_exp.size() != 0 || mem_exp.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < budget), 64'd1);
    repeat (2) @(negedge clk);
    check({tag, "_bus_sb_empty"}, 64'(bus_exp.size()), 64'd0);
  endtask

  task automatic wait_bus_req(input string tag);
    int n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_bus_req_timeout"}, 64'(bus_req), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"}, 64'(bus_req), 64'd0);
    check({tag, "_bus_we"}, 64'(bus_we), 64'd0);
    check({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
    check({tag, "_bus_wdata"}, 64'(bus_wdata), 64'd0);
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    check({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
    check({tag, "_if_done"}, 64'(if_done), 64'd0);
    check({tag, "_mem_done"}, 64'(mem_done), 64'd0);
  endtask

  // IF requester: holds if_req until done, loads the next fetch in the done cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (if_req && if_done) begin
        if (if_q.size() != 0) if_addr = if_q.pop_front();
        else if_req = 1'b0;
      end else if (!if_req && if_q.size() != 0) begin
        if_addr = if_q.pop_front();
        if_req  = 1'b1;
      end
    end
  end

  // MEM requester: same protocol, keeps mem_req high across back-to-back ops
  initial begin
    bus_tx_t op;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if ((mem_req && mem_done) || (!mem_req && mem_q.size() != 0)) begin
        if (mem_q.size() != 0) begin
          op = mem_q.pop_front();
          mem_we = op.we; mem_addr = op.addr; mem_wdata = op.wdata;
          mem_req = 1'b1;
        end else begin
          mem_req = 1'b0;
        end
      end
    end
  end

  // Bus responder: ack in the ack_delay-th cycle of bus_req; junk data otherwise
  initial begin
    forever begin
      @(negedge clk);
      bus_ack   = stray_ack;
      bus_rdata = 32'hBAD0_0000 | 32'(ack_wait);
      if (bus_req && rst_n) begin
        ack_wait++;
        if (ack_wait == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata_for(bus_addr);
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    logic    prev_req = 1'b0;
    bus_tx_t tx;
    logic [DW-1:0] d;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_req = 1'b0;
        continue;
      end
      if (bus_req && !prev_req) begin
        if (bus_exp.size() == 0) begin
          check("bus_unexpected_req", 64'(bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          tx = bus_exp.pop_front();
          check("bus_we", 64'(bus_we), 64'(tx.we));
          check("bus_addr", 64'(bus_addr), 64'(tx.addr));
          if (tx.we) check("bus_wdata", 64'(bus_wdata), 64'(tx.wdata));
        end
      end
      // bus_ack currently visible is the one the DUT sampled at this edge
      if (prev_req) check("bus_req_until_ack", 64'(bus_req), 64'(!bus_ack));
      if (if_done) begin
        check("if_done_after_ack", 64'(bus_ack), 64'd1);
        if (if_exp.size() == 0) begin
          check("if_done_unexpected", 64'(if_done), 64'd0);
        end else begin
          d = if_exp.pop_front();
          check("if_rdata", 64'(if_rdata), 64'(d));
        end
      end
      if (mem_done) begin
        check("mem_done_after_ack", 64'(bus_ack), 64'd1);
        if (mem_exp.size() == 0) begin
          check("mem_done_unexpected", 64'(mem_done), 64'd0);
        end else begin
          d = mem_exp.pop_front();
          check("mem_rdata", 64'(mem_rdata), 64'(d));
        end
      end
      check("if_stall", 64'(if_stall), 64'(if_req & ~if_done));
      check("mem_stall", 64'(mem_stall), 64'(mem_req & ~mem_done));
      prev_req = bus_req;
    end
  end

  // Directed stimulus
  initial begin
    int n;

    // reset state
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch, 1-cycle ack; done visible at the 3rd negedge after the push
    ack_delay = 1;
    @(posedge clk); #1;
    push_fetch(32'h40, 1'b1);
    exp_bus(1'b0, 32'h40, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_done && n < 10);
    check("fetch_latency", 64'(n), 64'd3);
    check("fetch_data", 64'(if_rdata), 64'h8C22_0004);
    wait_quiet("single_fetch", 50);

    // simultaneous request: MEM store wins, IF waits
    ack_delay = 2;
    @(posedge clk); #1;
    push_mem(1'b1, 32'h100, 32'hDEAD_BEEF);
    push_fetch(32'h80, 1'b1);
    exp_bus(1'b1, 32'h100, 32'hDEAD_BEEF);
    exp_bus(1'b0, 32'h80, 32'h0);
    wait_quiet("simultaneous", 60);

    // kill in the 2nd BUSY cycle of a fetch with a 3-cycle ack
    ack_delay = 3;
    @(posedge clk); #1;
    push_fetch(32'h44, 1'b0);
    exp_bus(1'b0, 32'h44, 32'h0);
    wait_bus_req("kill");
    @(negedge clk);
    if_kill = 1'b1;
    if_req  = 1'b0;
    @(negedge clk);
    if_kill = 1'b0;
    wait_quiet("kill", 50);

    // ack outside BUSY must be ignored
    @(posedge clk); #3;
    stray_ack = 1'b1;
    @(posedge clk); #3;
    stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ack_bus_req", 64'(bus_req), 64'd0);
    check("stray_ack_if_done", 64'(if_done), 64'd0);
    check("stray_ack_mem_done", 64'(mem_done), 64'd0);

    // variable ack latency on loads and a fetch
    ack_delay = 1;
    @(posedge clk); #1;
    push_mem(1'b0, 32'h204, 32'h0);
    exp_bus(1'b0, 32'h204, 32'h0);
    wait_quiet("latency_1", 50);
    ack_delay = 5;
    push_fetch(32'h214, 1'b1);
    exp_bus(1'b0, 32'h214, 32'h0);
    wait_quiet("latency_5", 50);
    ack_delay = 16;
    push_mem(1'b0, 32'h240, 32'h0);
    exp_bus(1'b0, 32'h240, 32'h0);
    wait_quiet("latency_16", 80);

    // reset mid-access
    ack_delay = 10;
    @(posedge clk); #1;
    push_fetch(32'h300, 1'b0);
    exp_bus(1'b0, 32'h300, 32'h0);
    wait_bus_req("reset_mid");
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    if_req = 1'b0;
    mem_req = 1'b0;
    if_q.delete(); mem_q.delete(); if_exp.delete(); mem_exp.delete(); bus_exp.delete();
    #1;
    check_all_zero("reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
    ack_delay = 2;
    push_fetch(32'h40, 1'b1);
    exp_bus(1'b0, 32'h40, 32'h0);
    wait_quiet("post_reset", 50);

    // starvation: MEM held continuously with IF pending
    ack_delay = 1;
    @(posedge clk); #1;
    push_fetch(32'h500, 1'b1);
    for (int i = 0; i < 6; i++) push_mem(1'b0, 32'h600 + 32'(4 * i), 32'h0);
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < STARVE_MAX; i++) exp_bus(1'b0, 32'h600 + 32'(4 * i), 32'h0);
    exp_bus(1'b0, 32'h500, 32'h0);
    for (int i = STARVE_MAX; i < 6; i++) exp_bus(1'b0, 32'h600 + 32'(4 * i), 32'h0);
`else
    for (int i = 0; i < 6; i++) exp_bus(1'b0, 32'h600 + 32'(4 * i), 32'h0);
    exp_bus(1'b0, 32'h500, 32'h0);
`endif
    wait_quiet("starve", 200);

    check("final_if_sb_empty", 64'(if_exp.size()), 64'd0);
    check("final_mem_sb_empty", 64'(mem_exp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
